// File: rtl/l2k_mmu_pkg.sv
// Limn2600 MMU shared types.
// TLB entry layout, opcodes and fault codes.
package l2k_mmu_pkg;

  localparam int VPN_W      = 20;
  localparam int ASID_W     = 12;
  localparam int PPN_W      = 20;
  localparam int PAGE_SHIFT = 12;

  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic              v;
    logic              w;
    logic              k;
    logic              nc;
    logic              g;
    logic [PPN_W-1:0]  ppn;
    logic [6:0]        avail;
  } tlb_entry_t;

  localparam logic [2:0] CMD_WRITE_IDX  = 3'd0;
  localparam logic [2:0] CMD_WRITE_RR   = 3'd1;
  localparam logic [2:0] CMD_INVAL_VA   = 3'd2;
  localparam logic [2:0] CMD_INVAL_ALL  = 3'd3;
  localparam logic [2:0] CMD_INVAL_ASID = 3'd4;

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_MISS  = 2'd1;
  localparam logic [1:0] FAULT_PRIV  = 2'd2;
  localparam logic [1:0] FAULT_WPROT = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } tlb_state_t;

endpackage

// File: rtl/l2k_tlb_match.sv
// Limn2600 TLB tag compare.
// Hit vector plus lowest-index priority encoder.
module l2k_tlb_match
  import l2k_mmu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [VPN_W-1:0]  vpns  [ENTRIES],
  input  logic [ASID_W-1:0] asids [ENTRIES],
  input  logic [ENTRIES-1:0] glob,
  input  logic [ENTRIES-1:0] valid,
  input  logic [VPN_W-1:0]  vpn,
  input  logic [ASID_W-1:0] asid,
  output logic [ENTRIES-1:0] hits,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // per-entry tag compare; global pages ignore the ASID
  always_comb begin
    hits = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hits[i] = valid[i] && (vpns[i] == vpn) &&
                (glob[i] || (asids[i] == asid));
    end
  end

  // scan downward so the lowest matching index wins
  always_comb begin
    hit = |hits;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hits[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/l2k_tlb.sv
// Limn2600 fully associative TLB.
// ASID tags, global pages, permission checks, sweep invalidation.
module l2k_tlb
  import l2k_mmu_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [11:0]       cur_asid,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_vaddr,
  input  logic              req_write,
  input  logic              req_kernel,
  output logic              rsp_valid,
  output logic [31:0]       rsp_paddr,
  output logic              rsp_nc,
  output logic [1:0]        rsp_fault,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_index,
  input  tlb_entry_t        cmd_entry,
  output logic              cmd_done
);

  tlb_state_t state;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   sweep_idx;
  logic               sweep_all;
  logic [ASID_W-1:0]  sweep_asid;
  logic [ENTRIES-1:0] valid;

  logic [VPN_W-1:0]   vpn_q  [ENTRIES];
  logic [ASID_W-1:0]  asid_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q  [ENTRIES];
  logic [ENTRIES-1:0] g_q;
  logic [ENTRIES-1:0] w_q;
  logic [ENTRIES-1:0] k_q;
  logic [ENTRIES-1:0] nc_q;

  logic               cmd_fire;
  logic               req_fire;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [VPN_W-1:0]   m_vpn;
  logic [ASID_W-1:0]  m_asid;
  logic [ENTRIES-1:0] m_hits;
  logic               m_hit;
  logic [IDX_W-1:0]   m_idx;
  logic               unused_avail;

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign req_ready = cmd_ready && !cmd_valid;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign req_fire  = req_valid && req_ready;

  assign wr_en  = cmd_fire && ((cmd_op == CMD_WRITE_IDX) ||
                               (cmd_op == CMD_WRITE_RR));
  assign wr_idx = (cmd_op == CMD_WRITE_IDX) ? cmd_index : rr_ptr;

  // a pending command owns the comparator, so lookups never share it
  assign m_vpn  = cmd_valid ? cmd_entry.vpn : req_vaddr[31:PAGE_SHIFT];
  assign m_asid = cmd_valid ? cmd_entry.asid : cur_asid;

  assign unused_avail = ^cmd_entry.avail;

  l2k_tlb_match #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_match (
    .vpns  (vpn_q),
    .asids (asid_q),
    .glob  (g_q),
    .valid (valid),
    .vpn   (m_vpn),
    .asid  (m_asid),
    .hits  (m_hits),
    .hit   (m_hit),
    .idx   (m_idx)
  );

  // entry payload storage; only valid bits are reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      vpn_q[wr_idx]  <= cmd_entry.vpn;
      asid_q[wr_idx] <= cmd_entry.asid;
      ppn_q[wr_idx]  <= cmd_entry.ppn;
      g_q[wr_idx]    <= cmd_entry.g;
      w_q[wr_idx]    <= cmd_entry.w;
      k_q[wr_idx]    <= cmd_entry.k;
      nc_q[wr_idx]   <= cmd_entry.nc;
    end
  end

  // command FSM: valid bits, round-robin pointer, sweeps, done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      valid      <= '0;
      rr_ptr     <= '0;
      sweep_idx  <= '0;
      sweep_all  <= 1'b0;
      sweep_asid <= '0;
      cmd_done   <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            case (cmd_op)
              CMD_WRITE_IDX: begin
                valid[cmd_index] <= cmd_entry.v;
                cmd_done         <= 1'b1;
              end
              CMD_WRITE_RR: begin
                valid[rr_ptr] <= cmd_entry.v;
                rr_ptr        <= rr_ptr + 1'b1;
                cmd_done      <= 1'b1;
              end
              CMD_INVAL_VA: begin
                valid    <= valid & ~m_hits;
                cmd_done <= 1'b1;
              end
              CMD_INVAL_ALL, CMD_INVAL_ASID: begin
                state      <= ST_SWEEP;
                sweep_idx  <= '0;
                sweep_all  <= (cmd_op == CMD_INVAL_ALL);
                sweep_asid <= cmd_entry.asid;
              end
              default: cmd_done <= 1'b1;
            endcase
          end
        end
        ST_SWEEP: begin
          if (sweep_all || (!g_q[sweep_idx] &&
              (asid_q[sweep_idx] == sweep_asid))) begin
            valid[sweep_idx] <= 1'b0;
          end
          if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
            state    <= ST_IDLE;
            cmd_done <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // registered lookup result with fault priority miss > priv > wprot
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_paddr <= '0;
      rsp_nc    <= 1'b0;
      rsp_fault <= FAULT_NONE;
    end else begin
      rsp_valid <= req_fire;
      if (req_fire) begin
        rsp_paddr <= '0;
        rsp_nc    <= 1'b0;
        if (!enable) begin
          rsp_paddr <= req_vaddr;
          rsp_fault <= FAULT_NONE;
        end else if (!m_hit) begin
          rsp_fault <= FAULT_MISS;
        end else if (k_q[m_idx] && !req_kernel) begin
          rsp_fault <= FAULT_PRIV;
        end else if (req_write && !w_q[m_idx]) begin
          rsp_fault <= FAULT_WPROT;
        end else begin
          rsp_paddr <= {ppn_q[m_idx], req_vaddr[PAGE_SHIFT-1:0]};
          rsp_nc    <= nc_q[m_idx];
          rsp_fault <= FAULT_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2k_tlb.sv
// Directed bench for l2k_tlb.
// Hand-computed expectations checked with immediate assertions.
module tb_l2k_tlb;
  import l2k_mmu_pkg::*;

  localparam int N  = 16;
  localparam int IW = $clog2(N);

  logic          clk;
  logic          rst;
  logic          enable;
  logic [11:0]   cur_asid;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_vaddr;
  logic          req_write;
  logic          req_kernel;
  logic          rsp_valid;
  logic [31:0]   rsp_paddr;
  logic          rsp_nc;
  logic [1:0]    rsp_fault;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [IW-1:0] cmd_index;
  tlb_entry_t    cmd_entry;
  logic          cmd_done;

  int checks = 0;
  int fails  = 0;
  logic done_seen;

  l2k_tlb #(.ENTRIES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cur_asid   (cur_asid),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vaddr  (req_vaddr),
    .req_write  (req_write),
    .req_kernel (req_kernel),
    .rsp_valid  (rsp_valid),
    .rsp_paddr  (rsp_paddr),
    .rsp_nc     (rsp_nc),
    .rsp_fault  (rsp_fault),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_index  (cmd_index),
    .cmd_entry  (cmd_entry),
    .cmd_done   (cmd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic tlb_entry_t mk(input logic [19:0] vpn,
                                    input logic [11:0] asid,
                                    input logic w, input logic k,
                                    input logic nc, input logic g,
                                    input logic [19:0] ppn);
    tlb_entry_t e;
    e      = '0;
    e.vpn  = vpn;
    e.asid = asid;
    e.v    = 1'b1;
    e.w    = w;
    e.k    = k;
    e.nc   = nc;
    e.g    = g;
    e.ppn  = ppn;
    return e;
  endfunction

  task automatic lookup(input logic [31:0] va, input logic wr,
                        input logic kn, input logic [11:0] asid,
                        input logic en);
    @(negedge clk);
    req_valid  = 1'b1;
    req_vaddr  = va;
    req_write  = wr;
    req_kernel = kn;
    cur_asid   = asid;
    enable     = en;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic rsp(input string tag, input logic [31:0] pa,
                     input logic [1:0] f, input logic nc);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".paddr"}, rsp_paddr, pa);
    chk({tag, ".fault"}, 32'(rsp_fault), 32'(f));
    chk({tag, ".nc"}, 32'(rsp_nc), 32'(nc));
  endtask

  task automatic cmd(input logic [2:0] op, input logic [IW-1:0] idx,
                     input tlb_entry_t e);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_index = idx;
    cmd_entry = e;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    cur_asid   = '0;
    req_valid  = 1'b1;
    req_vaddr  = 32'h0040_1234;
    req_write  = 1'b0;
    req_kernel = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_index  = '0;
    cmd_entry  = '0;

    // reset state, with a lookup held during reset
    repeat (2) @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_paddr", rsp_paddr, 32'd0);
    chk("rst.rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst.cmd_done", 32'(cmd_done), 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;

    // empty TLB miss, one-cycle pulse
    lookup(32'h0040_1234, 1'b0, 1'b0, 12'd7, 1'b1);
    rsp("miss0", 32'h0, FAULT_MISS, 1'b0);
    @(posedge clk); #1;
    chk("miss0.pulse", 32'(rsp_valid), 32'd0);

    // ASID-tagged hit, ASID mismatch, then global
    cmd(CMD_WRITE_IDX, IW'(5),
        mk(20'h00401, 12'd7, 1'b1, 1'b0, 1'b0, 1'b0, 20'h12345));
    chk("widx.done", 32'(cmd_done), 32'd1);
    lookup(32'h0040_1ABC, 1'b0, 1'b0, 12'd7, 1'b1);
    rsp("hit_asid7", 32'h1234_5ABC, FAULT_NONE, 1'b0);
    lookup(32'h0040_1ABC, 1'b0, 1'b0, 12'd8, 1'b1);
    rsp("miss_asid8", 32'h0, FAULT_MISS, 1'b0);
    cmd(CMD_WRITE_IDX, IW'(5),
        mk(20'h00401, 12'd7, 1'b1, 1'b0, 1'b0, 1'b1, 20'h12345));
    lookup(32'h0040_1ABC, 1'b0, 1'b0, 12'd8, 1'b1);
    rsp("hit_global", 32'h1234_5ABC, FAULT_NONE, 1'b0);

    // permissions on a kernel-only read-only nc page
    cmd(CMD_WRITE_IDX, IW'(6),
        mk(20'h00500, 12'd7, 1'b0, 1'b1, 1'b1, 1'b0, 20'hABCDE));
    lookup(32'h0050_0010, 1'b0, 1'b0, 12'd7, 1'b1);
    rsp("user_rd", 32'h0, FAULT_PRIV, 1'b0);
    lookup(32'h0050_0010, 1'b1, 1'b0, 12'd7, 1'b1);
    rsp("user_wr", 32'h0, FAULT_PRIV, 1'b0);
    lookup(32'h0050_0010, 1'b1, 1'b1, 12'd7, 1'b1);
    rsp("kern_wr", 32'h0, FAULT_WPROT, 1'b0);
    lookup(32'h0050_0010, 1'b0, 1'b1, 12'd7, 1'b1);
    rsp("kern_rd", 32'hABCD_E010, FAULT_NONE, 1'b1);

    // pass-through
    lookup(32'hDEAD_BEEF, 1'b1, 1'b0, 12'd9, 1'b0);
    rsp("bypass", 32'hDEAD_BEEF, FAULT_NONE, 1'b0);

    // round-robin fill with one wrap
    for (int i = 0; i <= N; i++) begin
      cmd(CMD_WRITE_RR, IW'(3),
          mk(20'(32'h10000 + i), 12'd0, 1'b1, 1'b0, 1'b0, 1'b1,
             20'(32'h20000 + i)));
    end
    chk("rr.done", 32'(cmd_done), 32'd1);
    lookup(32'h1000_0123, 1'b0, 1'b0, 12'd0, 1'b1);
    rsp("rr_old0", 32'h0, FAULT_MISS, 1'b0);
    lookup(32'h1001_0456, 1'b0, 1'b0, 12'd0, 1'b1);
    rsp("rr_wrap", 32'h2001_0456, FAULT_NONE, 1'b0);
    lookup(32'h1000_F000, 1'b0, 1'b0, 12'd0, 1'b1);
    rsp("rr_last", 32'h2000_F000, FAULT_NONE, 1'b0);

    // duplicate vpn: lowest index wins
    cmd(CMD_WRITE_IDX, IW'(2),
        mk(20'h30000, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h11111));
    cmd(CMD_WRITE_IDX, IW'(9),
        mk(20'h30000, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h22222));
    lookup(32'h3000_0777, 1'b0, 1'b0, 12'd0, 1'b1);
    rsp("dup", 32'h1111_1777, FAULT_NONE, 1'b0);

    // WRITE_IDX left rr_ptr at 1
    cmd(CMD_WRITE_RR, IW'(0),
        mk(20'h60000, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 20'h66666));
    lookup(32'h1000_1000, 1'b0, 1'b0, 12'd0, 1'b1);
    rsp("rr_ptr_old1", 32'h0, FAULT_MISS, 1'b0);
    lookup(32'h6000_0000, 1'b0, 1'b0, 12'd0, 1'b1);
    rsp("rr_ptr_new1", 32'h6666_6000, FAULT_NONE, 1'b0);

    // single-page invalidate clears both duplicates
    cmd(CMD_INVAL_VA, IW'(0),
        mk(20'h30000, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0));
    chk("inva.done", 32'(cmd_done), 32'd1);
    lookup(32'h3000_0777, 1'b0, 1'b0, 12'd0, 1'b1);
    rsp("inva_gone", 32'h0, FAULT_MISS, 1'b0);
    lookup(32'h1000_F000, 1'b0, 1'b0, 12'd0, 1'b1);
    rsp("inva_keep", 32'h2000_F000, FAULT_NONE, 1'b0);

    // ASID sweep: even indices global
    for (int i = 0; i < N; i++) begin
      cmd(CMD_WRITE_IDX, IW'(i),
          mk(20'(32'h40000 + i), 12'd3, 1'b1, 1'b0, 1'b0,
             (i % 2) == 0, 20'(32'h50000 + i)));
    end
    lookup(32'h4000_1000, 1'b0, 1'b0, 12'd3, 1'b1);
    rsp("asid_pre", 32'h5000_1000, FAULT_NONE, 1'b0);
    cmd(CMD_INVAL_ASID, IW'(0),
        mk(20'h0, 12'd3, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0));
    chk("sweep.req_ready", 32'(req_ready), 32'd0);
    done_seen = 1'b0;
    for (int c = 1; c <= N; c++) begin
      if (cmd_ready || cmd_done) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("sweep.busy", 32'(done_seen), 32'd0);
    chk("sweep.done", 32'(cmd_done), 32'd1);
    chk("sweep.idle", 32'(cmd_ready), 32'd1);
    lookup(32'h4000_0000, 1'b0, 1'b0, 12'd3, 1'b1);
    rsp("asid_g0", 32'h5000_0000, FAULT_NONE, 1'b0);
    lookup(32'h4000_1000, 1'b0, 1'b0, 12'd3, 1'b1);
    rsp("asid_ng1", 32'h0, FAULT_MISS, 1'b0);
    lookup(32'h4000_E000, 1'b0, 1'b0, 12'd3, 1'b1);
    rsp("asid_g14", 32'h5000_E000, FAULT_NONE, 1'b0);

    // INVAL_ALL aborted by reset at sweep cycle 10
    cmd(CMD_INVAL_ALL, IW'(0), '0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.done", 32'(cmd_done), 32'd0);
    chk("abort.rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.idle", 32'(cmd_ready), 32'd1);
    done_seen = 1'b0;
    repeat (N + 2) begin
      @(posedge clk); #1;
      if (cmd_done) done_seen = 1'b1;
    end
    chk("abort.no_done", 32'(done_seen), 32'd0);
    lookup(32'h4000_0000, 1'b0, 1'b0, 12'd3, 1'b1);
    rsp("abort_e0", 32'h0, FAULT_MISS, 1'b0);
    lookup(32'h4000_C000, 1'b0, 1'b0, 12'd3, 1'b1);
    rsp("abort_e12", 32'h0, FAULT_MISS, 1'b0);
    lookup(32'h6000_0000, 1'b0, 1'b0, 12'd0, 1'b1);
    rsp("abort_rr", 32'h0, FAULT_MISS, 1'b0);

    // command beats lookup in the same cycle
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd7;
    req_valid = 1'b1;
    req_vaddr = 32'h1234_5678;
    #1;
    chk("prio.req_ready", 32'(req_ready), 32'd0);
    chk("prio.cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    req_valid = 1'b0;
    chk("prio.done", 32'(cmd_done), 32'd1);
    chk("prio.no_rsp", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/l2k_tlb.md
Name: l2k_tlb

Overview:
Parametrised, fully associative Limn2600 TLB with ASID tagging, global pages and per-access permission checks. It sits between the load/store and fetch address path and the bus interface.
- Enabled: translates 32-bit virtual addresses (4 KiB pages) with one-cycle registered latency.
- Disabled: passes addresses through unchanged.
- Software maintains it through a command port: indexed write, round-robin write, single-page invalidate, ASID invalidate and full invalidate.

Parameters:
ENTRIES, 64, number of TLB entries; power of two, 4..64.
IDX_W, $clog2(ENTRIES), index width; derived, never overridden.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
enable  in  1  translation on (1) or identity pass-through (0); sampled with each request
cur_asid  in  12  current address-space ID; sampled with each request
req_valid  in  1  lookup request
req_ready  out  1  lookup accepted when req_valid && req_ready
req_vaddr  in  32  virtual address
req_write  in  1  access is a store
req_kernel  in  1  access is in kernel mode
rsp_valid  out  1  one-cycle pulse carrying the result; no backpressure
rsp_paddr  out  32  physical address
rsp_nc  out  1  non-cacheable page
rsp_fault  out  2  0 none, 1 miss, 2 privilege, 3 write-protect
cmd_valid  in  1  maintenance command
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  3  0 WRITE_IDX, 1 WRITE_RR, 2 INVAL_VA, 3 INVAL_ALL, 4 INVAL_ASID; 5..7 no-op
cmd_index  in  IDX_W  target index for WRITE_IDX
cmd_entry  in  64  tlb_entry_t: vpn[63:44] asid[43:32] v[31] w[30] k[29] nc[28] g[27] ppn[26:7] avail[6:0]
cmd_done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset: all V bits cleared; rr_ptr=0; FSM=IDLE.
- Reset outputs: rsp_valid=0, rsp_paddr=0, rsp_nc=0, rsp_fault=0, cmd_done=0, req_ready=0, cmd_ready=0.
- Other entry fields are not reset.
- Reset mid-sweep aborts the sweep with no cmd_done; all entries end invalid.
- FSM states: IDLE, SWEEP.
- req_ready = (state==IDLE) && !cmd_valid && !rst. Commands take priority over lookups in the same cycle.
- cmd_ready = (state==IDLE) && !rst.
- Lookup, accepted at cycle N; rsp_* is registered and valid at N+1. A request may be accepted every cycle.
- Hit condition per entry: v && vpn==vaddr[31:12] && (g || asid==cur_asid).
- Multiple hits: the lowest index wins.
- Fault priority:
  - miss (1): no entry hits.
  - privilege (2): entry k=1 and req_kernel=0.
  - write-protect (3): req_write=1 and entry w=0.
- On a hit: rsp_paddr = {ppn, vaddr[11:0]}. On any fault: rsp_paddr=0 and rsp_nc=0.
- enable=0: rsp_paddr=vaddr, rsp_nc=0, rsp_fault=0; latency still 1 cycle.
- WRITE_IDX: tlb[cmd_index] <= cmd_entry at the accept edge; cmd_done at N+1.
- WRITE_RR: tlb[rr_ptr] <= cmd_entry; rr_ptr <= rr_ptr+1, wrapping ENTRIES-1 -> 0; cmd_done at N+1.
- WRITE_IDX does not move rr_ptr.
- INVAL_VA: in one cycle, clear v on every entry matching cmd_entry.vpn where (g || asid==cmd_entry.asid); cmd_done at N+1.
- INVAL_ALL / INVAL_ASID: enter SWEEP with sweep_idx=0.
  - Each cycle processes one entry. INVAL_ALL clears v. INVAL_ASID clears v only where g==0 && asid==cmd_entry.asid.
  - At sweep_idx==ENTRIES-1: return to IDLE and pulse cmd_done in the next cycle. Total latency is ENTRIES+1 cycles from accept.
  - No lookup or command is accepted during SWEEP.
- Opcodes 5..7: accepted with no effect; cmd_done at N+1.
- A write lands before any lookup accepted in a later cycle. There are no same-cycle hazards, because a command blocks lookups in its accept cycle.

Decomposition:
- Package l2k_mmu_pkg:
  - tlb_entry_t packed struct (layout above).
  - Widths: VPN_W=20, ASID_W=12, PPN_W=20, PAGE_SHIFT=12.
  - Opcode localparams CMD_WRITE_IDX..CMD_INVAL_ASID.
  - Fault codes FAULT_NONE/MISS/PRIV/WPROT.
- Sub-module l2k_tlb_match: combinational hit vector plus lowest-index priority encoder (hit, idx). It is shared by the lookup path and INVAL_VA.

Test Plan:
- Reset, then enable=1, lookup 0x0040_1234 -> rsp_valid at N+1, fault=1, paddr=0; req_ready=0 while rst.
- WRITE_IDX idx 5 {vpn 0x00401, asid 7, v=1, w=1, k=0, ppn 0x12345}; lookup 0x0040_1ABC with asid 7 -> paddr 0x1234_5ABC, fault=0; same lookup with asid 8 -> miss; set g=1 -> hit with asid 8.
- Entry k=1, w=0: user read -> fault=2; kernel write -> fault=3; kernel read -> hit; enable=0 with vaddr 0xDEAD_BEEF -> paddr 0xDEAD_BEEF, fault=0.
- ENTRIES+1 WRITE_RR commands -> entries 0..ENTRIES-1 filled, then entry 0 overwritten (wrap); duplicate vpn at idx 2 and 9 -> idx 2 ppn returned.
- Fill entries with asid 3 (half g=1); INVAL_ASID asid 3 -> cmd_ready=0 for ENTRIES cycles, cmd_done at accept+ENTRIES+1; only global entries still hit.
- INVAL_ALL with rst asserted at sweep cycle 10 -> no cmd_done; FSM IDLE; every lookup misses. Command and lookup asserted in the same cycle -> command accepted, req_ready=0 that cycle.
